// File: rtl/pad_gpio_ctrl_pkg.sv
// Shared constants and pad drive-mode encoding for the GPIO pad controller.
// pad_drive() maps one pin's core request onto the pad cell c2p/c2p_en pair.
package pad_gpio_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEB_W = 8;

   typedef enum logic {
      PAD_PUSH_PULL  = 1'b0,
      PAD_OPEN_DRAIN = 1'b1
   } pad_mode_e;

   typedef struct packed {
      logic c2p;
      logic c2p_en;
   } pad_drive_t;

   // Open-drain pins only ever pull low: driving a 1 means releasing the pad.
   function automatic pad_drive_t pad_drive(pad_mode_e mode, logic value, logic enable);
      pad_drive_t d;
      d.c2p    = 1'b0;
      d.c2p_en = 1'b0;
      case (mode)
         PAD_PUSH_PULL: begin
            d.c2p    = value;
            d.c2p_en = enable;
         end
         PAD_OPEN_DRAIN: begin
            d.c2p    = 1'b0;
            d.c2p_en = enable & ~value;
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pad_gpio_ctrl_if.sv
// Signal bundle between the core/pad side (master) and the GPIO controller (slave).
// There is no valid/ready handshake: every signal is a level, sampled on each rising clk edge.
interface pad_gpio_ctrl_if #(
   parameter int WIDTH = pad_gpio_ctrl_pkg::DEFAULT_WIDTH,
   parameter int DEB_W = pad_gpio_ctrl_pkg::DEFAULT_DEB_W
);

   logic [WIDTH-1:0] out_value;
   logic [WIDTH-1:0] out_enable;
   logic [WIDTH-1:0] open_drain;
   logic [DEB_W-1:0] deb_limit;
   logic [WIDTH-1:0] irq_rise_en;
   logic [WIDTH-1:0] irq_fall_en;
   logic [WIDTH-1:0] irq_clear;
   logic [WIDTH-1:0] pad_p2c;
   logic [WIDTH-1:0] pad_c2p;
   logic [WIDTH-1:0] pad_c2p_en;
   logic [WIDTH-1:0] in_value;
   logic [WIDTH-1:0] irq_pending;
   logic             irq;

   modport master (
      output out_value, out_enable, open_drain, deb_limit,
      output irq_rise_en, irq_fall_en, irq_clear, pad_p2c,
      input  pad_c2p, pad_c2p_en, in_value, irq_pending, irq
   );

   modport slave (
      input  out_value, out_enable, open_drain, deb_limit,
      input  irq_rise_en, irq_fall_en, irq_clear, pad_p2c,
      output pad_c2p, pad_c2p_en, in_value, irq_pending, irq
   );

endinterface

// File: rtl/pad_gpio_pin.sv
// One GPIO pin: registered pad drive, two-flop input synchronizer, debounce
// against a shared hold count, and sticky rise/fall edge flags.
module pad_gpio_pin
   import pad_gpio_ctrl_pkg::*;
#(
   parameter int DEB_W = DEFAULT_DEB_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             out_value,
   input  logic             out_enable,
   input  logic             open_drain,
   input  logic [DEB_W-1:0] deb_limit,
   input  logic             irq_rise_en,
   input  logic             irq_fall_en,
   input  logic             irq_clear,
   input  logic             pad_p2c,
   output logic             pad_c2p,
   output logic             pad_c2p_en,
   output logic             in_value,
   output logic             irq_pending
);

   pad_mode_e        mode;
   pad_drive_t       drive_next;
   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_next;
   logic             stable_d_q;
   logic [DEB_W-1:0] count_q;
   logic [DEB_W-1:0] count_next;
   logic             pending_q;
   logic             pending_next;
   logic             rise;
   logic             fall;

   assign mode       = pad_mode_e'(open_drain);
   assign drive_next = pad_drive(mode, out_value, out_enable);

   // Debounce: the count only advances while sync2 disagrees with stable.
   // Using >= makes a limit lowered below the running count take effect at once.
   always_comb begin
      stable_next = stable_q;
      count_next  = count_q;
      if (sync2_q == stable_q) begin
         count_next = '0;
      end else if (count_q >= deb_limit) begin
         stable_next = sync2_q;
         count_next  = '0;
      end else begin
         count_next = count_q + 1'b1;
      end
   end

   // A new edge outranks a simultaneous clear so it is never lost.
   always_comb begin
      rise         = stable_q & ~stable_d_q & irq_rise_en;
      fall         = ~stable_q & stable_d_q & irq_fall_en;
      pending_next = rise | fall | (pending_q & ~irq_clear);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         stable_q   <= 1'b0;
         stable_d_q <= 1'b0;
         count_q    <= '0;
         pending_q  <= 1'b0;
         pad_c2p    <= 1'b0;
         pad_c2p_en <= 1'b0;
      end else begin
         sync1_q    <= pad_p2c;
         sync2_q    <= sync1_q;
         stable_q   <= stable_next;
         stable_d_q <= stable_q;
         count_q    <= count_next;
         pending_q  <= pending_next;
         pad_c2p    <= drive_next.c2p;
         pad_c2p_en <= drive_next.c2p_en;
      end
   end

   assign in_value    = stable_q;
   assign irq_pending = pending_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// GPIO pad controller top: WIDTH independent pad_gpio_pin slices plus the
// combined interrupt line.
module pad_gpio_ctrl
   import pad_gpio_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEB_W = DEFAULT_DEB_W
) (
   input logic            clk,
   input logic            resetn,
   pad_gpio_ctrl_if.slave bus
);

   logic [WIDTH-1:0] c2p;
   logic [WIDTH-1:0] c2p_en;
   logic [WIDTH-1:0] in_val;
   logic [WIDTH-1:0] pending;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      pad_gpio_pin #(
         .DEB_W(DEB_W)
      ) u_pin (
         .clk         (clk),
         .resetn      (resetn),
         .out_value   (bus.out_value[i]),
         .out_enable  (bus.out_enable[i]),
         .open_drain  (bus.open_drain[i]),
         .deb_limit   (bus.deb_limit),
         .irq_rise_en (bus.irq_rise_en[i]),
         .irq_fall_en (bus.irq_fall_en[i]),
         .irq_clear   (bus.irq_clear[i]),
         .pad_p2c     (bus.pad_p2c[i]),
         .pad_c2p     (c2p[i]),
         .pad_c2p_en  (c2p_en[i]),
         .in_value    (in_val[i]),
         .irq_pending (pending[i])
      );
   end

   assign bus.pad_c2p     = c2p;
   assign bus.pad_c2p_en  = c2p_en;
   assign bus.in_value    = in_val;
   assign bus.irq_pending = pending;
   assign bus.irq         = |pending;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Bench for pad_gpio_ctrl: a cycle reference model feeds an expected queue that
// a negedge monitor drains, alongside directed latency/glitch/collision/reset cases.
module tb_pad_gpio_ctrl;
   import pad_gpio_ctrl_pkg::*;

   localparam int WIDTH = DEFAULT_WIDTH;
   localparam int DEB_W = DEFAULT_DEB_W;
   localparam int VW    = 4 * WIDTH + 1;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_errors;

   logic [VW-1:0] exp_q[$];

   pad_gpio_ctrl_if #(.WIDTH(WIDTH), .DEB_W(DEB_W)) bus ();

   pad_gpio_ctrl #(.WIDTH(WIDTH), .DEB_W(DEB_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- shared checker ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The pin level seen by the core flips once the synchronized input has
   // disagreed with it for deb_limit+1 consecutive samples; kept as a history.
   logic [WIDTH-1:0] m_s1, m_s2, m_stable, m_prev, m_pend, m_c2p, m_en;
   logic [WIDTH-1:0] hist[$];

   always @(posedge clk) begin : model
      logic [WIDTH-1:0] new_stable, edge_set, h;
      int lim;
      bit ok;
      if (!resetn) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
         m_pend = '0; m_c2p = '0; m_en = '0;
         hist.delete();
      end else begin
         edge_set = (m_stable & ~m_prev & bus.irq_rise_en) |
                    (~m_stable & m_prev & bus.irq_fall_en);
         m_pend = (m_pend & ~bus.irq_clear) | edge_set;
         hist.push_back(m_s2);
         if (hist.size() > 300) void'(hist.pop_front());
         lim = int'(bus.deb_limit);
         new_stable = m_stable;
         for (int p = 0; p < WIDTH; p++) begin
            if (hist.size() >= lim + 1) begin
               ok = 1'b1;
               for (int k = 0; k <= lim; k++) begin
                  h = hist[hist.size() - 1 - k];
                  if (h[p] == m_stable[p]) ok = 1'b0;
               end
               if (ok) new_stable[p] = ~m_stable[p];
            end
         end
         m_prev   = m_stable;
         m_stable = new_stable;
         m_s2     = m_s1;
         m_s1     = bus.pad_p2c;
         for (int p = 0; p < WIDTH; p++) begin
            if (bus.open_drain[p]) begin
               m_c2p[p] = 1'b0;
               m_en[p]  = bus.out_enable[p] && !bus.out_value[p];
            end else begin
               m_c2p[p] = bus.out_value[p];
               m_en[p]  = bus.out_enable[p];
            end
         end
      end
      exp_q.push_back({m_c2p, m_en, m_stable, m_pend, (m_pend != '0)});
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      logic [VW-1:0] exp_v, act;
      act = {bus.pad_c2p, bus.pad_c2p_en, bus.in_value, bus.irq_pending, bus.irq};
      if (exp_q.size() == 0) begin
         check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
         exp_v = exp_q.pop_front();
         // A reset asserted after the model's edge wipes that edge's outputs.
         if (!resetn) exp_v = '0;
         check("sb_outputs", 64'(act), 64'(exp_v));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic rand_phase(input int lim, input int cycles);
      bus.deb_limit = DEB_W'(lim);
      for (int c = 0; c < cycles; c++) begin
         for (int p = 0; p < WIDTH; p++)
            if ($urandom_range(0, 7) == 0) bus.pad_p2c[p] = ~bus.pad_p2c[p];
         bus.out_value  = WIDTH'($urandom);
         bus.out_enable = WIDTH'($urandom);
         bus.open_drain = WIDTH'($urandom);
         if (c % 16 == 0) begin
            bus.irq_rise_en = WIDTH'($urandom);
            bus.irq_fall_en = WIDTH'($urandom);
         end
         bus.irq_clear = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
         tick();
      end
      bus.irq_clear = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int  n;
      logic seen;
      n_checks = 0;
      n_errors = 0;
      resetn          = 1'b0;
      bus.out_value   = '0;
      bus.out_enable  = '0;
      bus.open_drain  = '0;
      bus.deb_limit   = DEB_W'(4);
      bus.irq_rise_en = '0;
      bus.irq_fall_en = '0;
      bus.irq_clear   = '0;
      bus.pad_p2c     = '0;
      tick(3);
      check("reset_c2p_en", 64'(bus.pad_c2p_en), 64'd0);
      resetn = 1'b1;

      // Push-pull drive appears one edge later.
      bus.out_enable = 8'h01;
      bus.out_value  = 8'h01;
      tick();
      check("pp_c2p", 64'(bus.pad_c2p[0]), 64'd1);
      check("pp_c2p_en", 64'(bus.pad_c2p_en[0]), 64'd1);

      // Open-drain: drive low only.
      bus.open_drain = 8'h01;
      bus.out_value  = 8'h00;
      tick();
      check("od_low_en", 64'(bus.pad_c2p_en[0]), 64'd1);
      check("od_low_c2p", 64'(bus.pad_c2p[0]), 64'd0);
      bus.out_value = 8'h01;
      tick();
      check("od_high_en", 64'(bus.pad_c2p_en[0]), 64'd0);
      check("od_high_c2p", 64'(bus.pad_c2p[0]), 64'd0);

      // Latency 3 + deb_limit with a rise flag one edge later.
      bus.irq_rise_en = 8'h04;
      bus.pad_p2c[2]  = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.in_value[2]) begin
            n = i;
            break;
         end
      end
      check("latency_lim4", 64'(n), 64'd7);
      check("rise_not_yet", 64'(bus.irq_pending[2]), 64'd0);
      tick();
      check("rise_flag", 64'(bus.irq_pending[2]), 64'd1);
      bus.irq_rise_en = '0;
      tick(2);
      check("flag_sticky_en_off", 64'(bus.irq_pending[2]), 64'd1);
      bus.irq_clear = 8'h04;
      tick();
      bus.irq_clear = '0;
      check("flag_cleared", 64'(bus.irq_pending[2]), 64'd0);

      // Glitch shorter than the hold count is rejected.
      bus.irq_rise_en = 8'h08;
      bus.pad_p2c[3]  = 1'b1;
      tick(3);
      bus.pad_p2c[3]  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus.in_value[3] | bus.irq;
      end
      check("glitch_reject", 64'(seen), 64'd0);

      // Set and clear in the same cycle: set wins.
      bus.deb_limit   = DEB_W'(2);
      bus.irq_rise_en = '0;
      bus.irq_fall_en = 8'h02;
      bus.pad_p2c[1]  = 1'b1;
      tick(10);
      check("pin1_high", 64'(bus.in_value[1]), 64'd1);
      bus.pad_p2c[1] = 1'b0;
      tick(4);
      check("fall_lat_before", 64'(bus.in_value[1]), 64'd1);
      tick();
      check("fall_lat_at", 64'(bus.in_value[1]), 64'd0);
      bus.irq_clear = 8'h02;
      tick();
      bus.irq_clear = '0;
      check("collision_set_wins", 64'(bus.irq_pending[1]), 64'd1);
      bus.irq_clear = 8'h02;
      tick();
      bus.irq_clear = '0;
      check("late_clear", 64'(bus.irq_pending[1]), 64'd0);
      check("late_clear_irq", 64'(bus.irq), 64'd0);

      // Asynchronous reset mid-count, released with pads low.
      bus.deb_limit   = DEB_W'(4);
      bus.open_drain  = '0;
      bus.out_enable  = 8'hFF;
      bus.out_value   = 8'hAA;
      bus.irq_rise_en = 8'hFF;
      bus.irq_fall_en = 8'hFF;
      bus.pad_p2c[5]  = 1'b1;
      tick(4);
      check("pre_reset_c2p", 64'(bus.pad_c2p), 64'hAA);
      #1;
      resetn = 1'b0;
      #1;
      check("async_rst_outputs",
            64'({bus.pad_c2p, bus.pad_c2p_en, bus.in_value, bus.irq_pending, bus.irq}), 64'd0);
      bus.pad_p2c = '0;
      tick(2);
      resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus.irq | (bus.in_value != '0);
      end
      check("post_reset_quiet", 64'(seen), 64'd0);

      // Randomized phases across several hold counts.
      rand_phase(0, 300);
      rand_phase(1, 300);
      rand_phase(3, 300);
      rand_phase(6, 300);
      rand_phase(2, 200);

      tick(3);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pad_gpio_ctrl.md
PAD_GPIO_CTRL -- requirements
Module: pad_gpio_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, number of GPIO pins, each served by one InOut pad cell.
REQ-002: Parameter DEB_W, default 8, debounce counter width in bits.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: resetn  input  1  asynchronous, active-low reset.
REQ-005: out_value  input  WIDTH  core-requested output level per pin.
REQ-006: out_enable  input  WIDTH  per-pin drive enable, 1 = drive.
REQ-007: open_drain  input  WIDTH  per-pin open-drain mode, 1 = drive low only.
REQ-008: deb_limit  input  DEB_W  debounce hold count, shared by all pins.
REQ-009: irq_rise_en / irq_fall_en  input  WIDTH  per-pin edge-interrupt enables.
REQ-010: irq_clear  input  WIDTH  per-pin write-1-to-clear of pending flags.
REQ-011: pad_p2c  input  WIDTH  asynchronous level from the pad cell p2c pins.
REQ-012: pad_c2p  output  WIDTH  registered level to the pad cell c2p pins.
REQ-013: pad_c2p_en  output  WIDTH  registered enable to the pad cell c2p_en pins.
REQ-014: in_value  output  WIDTH  synchronized, debounced pin level.
REQ-015: irq_pending  output  WIDTH  sticky per-pin edge flags.
REQ-016: irq  output  1  OR-reduction of irq_pending.

Function
REQ-017: Push-pull pin (open_drain=0): pad_c2p <= out_value and pad_c2p_en <= out_enable, one cycle after the inputs are sampled.
REQ-018: Open-drain pin: pad_c2p <= 0 and pad_c2p_en <= out_enable & ~out_value; the pad is never driven high.
REQ-019: Each pad_p2c bit passes through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-020: Per-pin stable register plus DEB_W-bit counter.
- sync2 == stable: counter <= 0.
- sync2 != stable and counter == deb_limit: stable <= sync2, counter <= 0.
- Otherwise: counter <= counter + 1.
REQ-021: Glitch handling: any sync2 return to the stable value before the limit is reached restarts the count from 0.
REQ-022: Latency: a pad_p2c change held steady appears on in_value after exactly 3 + deb_limit rising edges; deb_limit = 0 gives 3 cycles.
REQ-023: Counter bound: the counter never exceeds deb_limit and never wraps.
REQ-024: deb_limit change mid-count: the comparison uses the current value each cycle; if counter > new limit, the next cycle treats the counter as equal, so stable updates.
REQ-025: in_value = stable register, driven directly with no extra logic.
REQ-026: Edge flags: a stable 0->1 with irq_rise_en set, or 1->0 with irq_fall_en set, sets irq_pending in the cycle after stable changes.
REQ-027: Flags stay set until cleared by irq_clear.
REQ-028: Set and irq_clear on the same pin in the same cycle: set wins, and the flag stays 1.
REQ-029: Clearing an enable does not clear its pending flag.
REQ-030: irq is the combinational OR of irq_pending.

Reset
REQ-031: On resetn low, regardless of clk, the following SHALL go to 0: sync1, sync2, stable, counters, irq_pending, pad_c2p, pad_c2p_en; all pads therefore tristate.
REQ-032: Leaving reset with pad_p2c = 1: in_value rises after 3 + deb_limit cycles and raises a rise flag if enabled; this is intended.
REQ-033: Reset mid-debounce discards the count; no flag is set for a discarded edge.

Structure
REQ-034: Shared package holds default WIDTH/DEB_W constants and the pad-mode encoding (push-pull, open-drain).
REQ-035: One sub-module, pad_gpio_pin, implements the per-pin synchronizer, debounce, edge detect and output register; the top generates WIDTH instances and the irq OR.

Verification
REQ-036: Push-pull drive: out_enable=0x01, out_value=0x01, open_drain=0 -> next cycle pad_c2p[0]=1, pad_c2p_en[0]=1.
REQ-037: Open-drain: open_drain[0]=1, out_enable[0]=1; out_value 0 -> c2p_en=1, c2p=0; out_value 1 -> c2p_en=0.
REQ-038: Latency: deb_limit=4, pad_p2c[2] 0->1 held -> in_value[2]=1 exactly 7 cycles later; irq_pending[2]=1 one cycle after, with irq_rise_en[2]=1.
REQ-039: Glitch rejection: deb_limit=4, pad_p2c[3] high for 3 cycles then low -> in_value[3] stays 0 and irq stays 0.
REQ-040: Set/clear collision: fall edge on pin 1 lands in the same cycle as irq_clear[1]=1 -> irq_pending[1] remains 1; a later clear -> 0 and irq=0.
REQ-041: Async reset: assert resetn low mid-count between clock edges -> all outputs 0 immediately; deassert with pad_p2c=0 -> no flags set.
